// File: rtl/demo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demo_pkg
// Description : Shared types and constants for the demo scene sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package demo_pkg;

    localparam int c_MODE_W  = 4;
    localparam int c_COLOR_W = 6;
    localparam int c_DUR_W   = 8;
    localparam int SCENE_W   = c_DUR_W + c_COLOR_W + 2 + c_MODE_W;

    // Field order fixes the bit positions: mode[3:0], loop_en[4], sprite_sel[5],
    // color[11:6], dur[19:12].
    typedef struct packed {
        logic [c_DUR_W-1:0]   dur;
        logic [c_COLOR_W-1:0] color;
        logic                 sprite_sel;
        logic                 loop_en;
        logic [c_MODE_W-1:0]  mode;
    } scene_t;

    localparam logic [2:0] c_PH_R = 3'b100;
    localparam logic [2:0] c_PH_G = 3'b010;
    localparam logic [2:0] c_PH_B = 3'b001;

    localparam int                 c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_HOLD = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WR_R = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_WR_G = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WR_B = 2'd3;

    function automatic logic [7:0] wr_code(input logic [2:0] phase, input logic [1:0] val);
        return {phase, 3'b000, val};
    endfunction

    function automatic logic [7:0] steady_code(input logic sprite_sel, input logic loop_en,
                                               input logic [c_MODE_W-1:0] mode);
        return {2'b00, sprite_sel, loop_en, mode};
    endfunction

endpackage
`default_nettype wire

// File: rtl/demo_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : demo_sequencer_if
// Description : User-input and colour-stage control bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface demo_sequencer_if;
    logic       frame_start;
    logic       manual_en;
    logic [7:0] manual_ctrl;
    logic       pause;
    logic       step;
    logic [7:0] vga_control;
    logic [3:0] scene_idx;
    logic       busy;

    modport master (
        output frame_start, manual_en, manual_ctrl, pause, step,
        input  vga_control, scene_idx, busy
    );

    modport slave (
        input  frame_start, manual_en, manual_ctrl, pause, step,
        output vga_control, scene_idx, busy
    );
endinterface
`default_nettype wire

// File: rtl/scene_rom.sv
`default_nettype none
// ============================================================================
// Module      : scene_rom
// Description : Fixed 16-entry scene script, combinational lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module scene_rom
    import demo_pkg::*;
(
    input  logic [3:0] i_idx,
    output scene_t     o_scene
);
    logic [SCENE_W-1:0] w_word;

    // Entries with sprite_sel=1 keep color[1:0]==mode[1:0] so the aliased
    // steady code rewrites blue with the value it already holds.
    always_comb begin
        w_word = '0;
        case (i_idx)
            4'd0:  w_word = 20'h02D01;
            4'd1:  w_word = 20'h01BA6;
            4'd2:  w_word = 20'h033DA;
            4'd3:  w_word = 20'h04FC2;
            4'd4:  w_word = 20'h02475;
            4'd5:  w_word = 20'h01803;
            4'd6:  w_word = 20'h05317;
            4'd7:  w_word = 20'h00AAE;
            4'd8:  w_word = 20'h03544;
            4'd9:  w_word = 20'h02C08;
            4'd10: w_word = 20'h010EF;
            4'd11: w_word = 20'h066D9;
            4'd12: w_word = 20'h021CB;
            4'd13: w_word = 20'h04E0C;
            4'd14: w_word = 20'h0191D;
            4'd15: w_word = 20'hFFF20;
            default: w_word = '0;
        endcase
    end

    assign o_scene = w_word;

endmodule
`default_nettype wire

// File: rtl/demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : demo_sequencer
// Description : Frame-synchronous scene scheduler driving the vga_control word.
// Revision    : 1.0 - initial release
// ============================================================================
module demo_sequencer
    import demo_pkg::*;
#(
    parameter int NUM_SCENES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    demo_sequencer_if.slave bus
);
    localparam logic [3:0] c_LAST_IDX = 4'(NUM_SCENES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [7:0]           r_frame_cnt;
    logic [7:0]           r_dur;
    logic [7:0]           r_vga_control;
    logic [3:0]           r_scene_idx;
    logic                 r_step_pend;
    logic                 r_reload_pend;
    logic                 r_loaded;
    logic                 r_manual_q;
    logic                 r_busy;

    logic [3:0] w_next_idx;
    logic [3:0] w_rom_idx;
    scene_t     w_scene;
    logic [7:0] w_dur_last;
    logic       w_fs_hold;
    logic       w_manual_fall;
    logic       w_first_load;
    logic       w_step_adv;
    logic       w_expire_adv;
    logic       w_advance;
    logic       w_reload;
    logic       w_load;
    logic       w_count;

    assign w_next_idx    = (r_scene_idx == c_LAST_IDX) ? 4'd0 : r_scene_idx + 4'd1;
    // On an advance the ROM already looks at the next scene so the red write
    // leaves on the load edge; otherwise it tracks the current scene.
    assign w_rom_idx     = w_advance ? w_next_idx : r_scene_idx;
    assign w_dur_last    = r_dur - 8'd1;

    assign w_fs_hold     = bus.frame_start & (r_state == c_ST_HOLD) & ~bus.manual_en;
    assign w_manual_fall = r_manual_q & ~bus.manual_en;
    assign w_first_load  = w_fs_hold & ~r_loaded;
    assign w_step_adv    = w_fs_hold & r_loaded & bus.pause & (r_step_pend | bus.step);
    assign w_expire_adv  = w_fs_hold & r_loaded & ~bus.pause & (r_frame_cnt == w_dur_last);
    assign w_advance     = w_step_adv | w_expire_adv;
    assign w_reload      = w_fs_hold & r_loaded & ~w_advance & (r_reload_pend | w_manual_fall);
    assign w_load        = w_first_load | w_advance | w_reload;
    assign w_count       = w_fs_hold & r_loaded & ~bus.pause & ~w_load;

    scene_rom u_scene_rom (
        .i_idx   (w_rom_idx),
        .o_scene (w_scene)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_HOLD;
            r_frame_cnt   <= 8'd0;
            r_dur         <= 8'd0;
            r_vga_control <= 8'h00;
            r_scene_idx   <= 4'd0;
            r_step_pend   <= 1'b0;
            r_reload_pend <= 1'b0;
            r_loaded      <= 1'b0;
            r_manual_q    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_manual_q <= bus.manual_en;
            if (bus.manual_en) begin
                r_state       <= c_ST_HOLD;
                r_busy        <= 1'b0;
                r_vga_control <= bus.manual_ctrl;
            end else begin
                if (w_advance || !bus.pause) begin
                    r_step_pend <= 1'b0;
                end else if (bus.step) begin
                    r_step_pend <= 1'b1;
                end

                if (w_load) begin
                    r_reload_pend <= 1'b0;
                end else if (w_manual_fall) begin
                    r_reload_pend <= 1'b1;
                end

                if (w_load) begin
                    r_frame_cnt <= 8'd0;
                    r_dur       <= w_scene.dur;
                end else if (w_count) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end

                if (w_advance) begin
                    r_scene_idx <= w_next_idx;
                end
                if (w_first_load) begin
                    r_loaded <= 1'b1;
                end

                case (r_state)
                    c_ST_HOLD: begin
                        if (w_load) begin
                            r_state       <= c_ST_WR_R;
                            r_busy        <= 1'b1;
                            r_vga_control <= wr_code(c_PH_R, w_scene.color[5:4]);
                        end
                    end
                    c_ST_WR_R: begin
                        r_state       <= c_ST_WR_G;
                        r_vga_control <= wr_code(c_PH_G, w_scene.color[3:2]);
                    end
                    c_ST_WR_G: begin
                        r_state       <= c_ST_WR_B;
                        r_vga_control <= wr_code(c_PH_B, w_scene.color[1:0]);
                    end
                    default: begin
                        r_state       <= c_ST_HOLD;
                        r_busy        <= 1'b0;
                        r_vga_control <= steady_code(w_scene.sprite_sel, w_scene.loop_en,
                                                     w_scene.mode);
                    end
                endcase
            end
        end
    end

    assign bus.vga_control = r_vga_control;
    assign bus.scene_idx   = r_scene_idx;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_demo_sequencer
// Description : Scoreboard bench for demo_sequencer with a 3-scene script.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demo_sequencer;
    localparam int N_SC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demo_sequencer_if u_if ();

    demo_sequencer #(.NUM_SCENES(N_SC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct packed {
        int         edge_no;
        logic [3:0] idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] s;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Script as the block's user sees it: plain field values per scene.
    function automatic void scene_fields(input int i, output int mode, output int spr,
                                         output int lp, output int color, output int dur);
        case (i)
            0:       begin mode = 1;  spr = 0; lp = 0; color = 'b110100; dur = 2; end
            1:       begin mode = 6;  spr = 1; lp = 0; color = 'b101110; dur = 1; end
            default: begin mode = 10; spr = 0; lp = 1; color = 'b001111; dur = 3; end
        endcase
        if (dur == 0) dur = 256;
    endfunction

    function automatic exp_t make_exp(input int i, input int edge_no);
        int mode, spr, lp, color, dur;
        exp_t e;
        scene_fields(i, mode, spr, lp, color, dur);
        e.edge_no = edge_no;
        e.idx     = 4'(i);
        e.r       = 8'(128 + color / 16);
        e.g       = 8'(64 + (color / 4) % 4);
        e.b       = 8'(32 + color % 4);
        e.s       = 8'(spr * 32 + lp * 16 + mode);
        return e;
    endfunction

    function automatic int scene_dur(input int i);
        int mode, spr, lp, color, dur;
        scene_fields(i, mode, spr, lp, color, dur);
        return dur;
    endfunction

    // Reference model: scene timeline in frames, updated once per clock edge.
    int         edge_no       = 0;
    int         m_idx         = 0;
    int         m_frames      = 0;
    int         m_busy        = 0;
    bit         m_loaded      = 0;
    bit         m_step_pend   = 0;
    bit         m_reload_pend = 0;
    bit         m_prev_man    = 0;
    bit         m_load, m_adv, m_fall;
    bit         man_edge      = 0;
    logic [7:0] man_val       = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_no = 0; m_idx = 0; m_frames = 0; m_busy = 0;
            m_loaded = 0; m_step_pend = 0; m_reload_pend = 0; m_prev_man = 0;
            man_edge = 0;
            exp_q.delete();
        end else begin
            edge_no++;
            man_edge = u_if.manual_en;
            man_val  = u_if.manual_ctrl;
            if (u_if.manual_en) begin
                m_busy = 0;
            end else begin
                m_load = 0;
                m_adv  = 0;
                m_fall = m_prev_man;
                if (m_busy > 0) begin
                    m_busy--;
                end else if (u_if.frame_start) begin
                    if (!m_loaded) begin
                        m_loaded = 1;
                        m_load   = 1;
                    end else if (u_if.pause && (m_step_pend || u_if.step)) begin
                        m_adv = 1;
                    end else if (!u_if.pause && m_frames + 1 == scene_dur(m_idx)) begin
                        m_adv = 1;
                    end else if (m_reload_pend || m_fall) begin
                        m_load = 1;
                    end else if (!u_if.pause) begin
                        m_frames++;
                    end
                end
                if (m_adv || !u_if.pause) m_step_pend = 0;
                else if (u_if.step)       m_step_pend = 1;
                if (m_adv) begin
                    m_idx  = (m_idx + 1) % N_SC;
                    m_load = 1;
                end
                if (m_load) m_reload_pend = 0;
                else if (m_fall) m_reload_pend = 1;
                if (m_load) begin
                    m_frames = 0;
                    m_busy   = 3;
                    exp_q.push_back(make_exp(m_idx, edge_no));
                end
            end
            m_prev_man = u_if.manual_en;
        end
    end

    // Monitor: follows each write sequence the DUT presents.
    int   ph = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0;
        end else begin
            chk("scene_idx", 32'(u_if.scene_idx), 32'(m_idx));
            if (man_edge) begin
                ph = 0;
                chk("manual_pass", 32'(u_if.vga_control), 32'(man_val));
            end else if (ph == 1) begin
                chk("wr_g", 32'(u_if.vga_control), 32'(cur.g));
                chk("busy_g", 32'(u_if.busy), 32'd1);
                ph = 2;
            end else if (ph == 2) begin
                chk("wr_b", 32'(u_if.vga_control), 32'(cur.b));
                chk("busy_b", 32'(u_if.busy), 32'd1);
                ph = 3;
            end else if (ph == 3) begin
                chk("steady", 32'(u_if.vga_control), 32'(cur.s));
                chk("busy_end", 32'(u_if.busy), 32'd0);
                ph = 0;
            end else if (exp_q.size() > 0 && exp_q[0].edge_no == edge_no) begin
                cur = exp_q.pop_front();
                chk("wr_r", 32'(u_if.vga_control), 32'(cur.r));
                chk("wr_idx", 32'(u_if.scene_idx), 32'(cur.idx));
                chk("busy_r", 32'(u_if.busy), 32'd1);
                ph = 1;
            end else begin
                chk("idle_busy", 32'(u_if.busy), 32'd0);
            end
        end
    end

    task automatic frame(input int gap, input int step_at);
        for (int c = 0; c < gap; c++) begin
            u_if.frame_start = (c == 0);
            u_if.step        = (c == step_at);
            @(negedge clk);
        end
        u_if.frame_start = 1'b0;
        u_if.step        = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    int idx_before;

    initial begin
        u_if.frame_start = 1'b0;
        u_if.manual_en   = 1'b0;
        u_if.manual_ctrl = 8'h00;
        u_if.pause       = 1'b0;
        u_if.step        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vga", 32'(u_if.vga_control), 32'h00);
        chk("rst_idx", 32'(u_if.scene_idx), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Free-running script including wrap from the last scene to scene 0.
        repeat (14) frame($urandom_range(4, 10), -1);

        // Long pause, then three steps collapsing into one advance.
        u_if.pause = 1'b1;
        idx_before = m_idx;
        repeat (300) frame(4, -1);
        chk("pause_idx_hold", 32'(u_if.scene_idx), 32'(idx_before));
        repeat (3) begin
            u_if.step = 1'b1;
            @(negedge clk);
            u_if.step = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("step_no_early", 32'(u_if.scene_idx), 32'(idx_before));
        frame(6, -1);
        chk("step_one_adv", 32'(u_if.scene_idx), 32'((idx_before + 1) % N_SC));
        idx_before = m_idx;
        frame(6, 0);
        chk("step_same_cycle", 32'(u_if.scene_idx), 32'((idx_before + 1) % N_SC));
        u_if.pause = 1'b0;

        // Random mix; some frame_start pulses land inside write sequences.
        repeat (150) begin
            if ($urandom_range(0, 7) == 0) u_if.pause = ~u_if.pause;
            frame($urandom_range(2, 9),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
        end
        u_if.pause = 1'b0;

        // Manual override, entered right after a frame so a write may be in flight.
        for (int k = 0; k < 3; k++) begin
            frame(1, -1);
            u_if.manual_en   = 1'b1;
            u_if.manual_ctrl = (k == 0) ? 8'hA5 : 8'($urandom);
            @(negedge clk);
            chk("manual_1clk", 32'(u_if.vga_control), 32'(u_if.manual_ctrl));
            repeat (4) begin
                u_if.manual_ctrl = 8'($urandom);
                frame($urandom_range(1, 3), -1);
            end
            u_if.manual_en = 1'b0;
            repeat (3) @(negedge clk);
            frame(6, -1);
            repeat (4) frame($urandom_range(4, 8), -1);
        end

        // Asynchronous reset while the green write is on the output.
        do_reset();
        frame(1, -1);
        @(negedge clk);
        chk("pre_rst_wr_g", 32'(u_if.vga_control), 32'h41);
        #1 rst_n = 1'b0;
        #1;
        chk("async_vga", 32'(u_if.vga_control), 32'h00);
        chk("async_busy", 32'(u_if.busy), 32'd0);
        chk("async_idx", 32'(u_if.scene_idx), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        repeat (4) frame(5, -1);

        repeat (8) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
